// File: rtl/reg_bank16.sv
// reg_bank16: sixteen-entry register bank with a per-entry reservation scoreboard.
// Drives the packed read-mux bus and flags issue stalls on reservation conflicts.
module reg_bank16 #(
  parameter int unsigned WIDTH         = 64,
  parameter bit          HARDWIRE_ZERO = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [3:0]             wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rsv_en,
  input  logic [3:0]             rsv_addr,
  output logic [15:0][WIDTH-1:0] q,
  output logic [15:0]            busy,
  output logic [4:0]             busy_count,
  output logic                   rsv_stall
);

  logic [15:0] busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        wr_zero, rsv_zero;
  logic        wr_eff, rsv_eff;
  logic        same;
  logic        set_new, rel_old;
  logic [15:0] wr_hit, rsv_hit;

  assign wr_zero  = HARDWIRE_ZERO && (wr_addr == 4'd15);
  assign rsv_zero = HARDWIRE_ZERO && (rsv_addr == 4'd15);
  assign same     = (wr_addr == rsv_addr);

  assign rsv_stall = rsv_en & busy_q[rsv_addr] & ~(wr_en & same);

  assign wr_eff  = wr_en & ~wr_zero;
  assign rsv_eff = rsv_en & ~rsv_stall & ~rsv_zero;

  assign wr_hit  = wr_eff  ? (16'd1 << wr_addr)  : 16'd0;
  assign rsv_hit = rsv_eff ? (16'd1 << rsv_addr) : 16'd0;

  // Release first, then reserve: a same-entry pair nets to still-busy.
  assign busy_d = (busy_q & ~wr_hit) | rsv_hit;

  assign set_new = rsv_eff & ~busy_q[rsv_addr];
  assign rel_old = wr_eff & busy_q[wr_addr] & ~(rsv_eff & same);
  assign cnt_d   = cnt_q + {4'd0, set_new} - {4'd0, rel_old};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_ent
    if (HARDWIRE_ZERO && i == 15) begin : g_zero
      assign q[i] = '0;
    end else begin : g_reg
      logic [WIDTH-1:0] data_q;
      always_ff @(posedge clk) begin
        if (reset)
          data_q <= '0;
        else if (wr_hit[i])
          data_q <= wr_data;
      end
      assign q[i] = data_q;
    end
  end

  assign busy       = busy_q;
  assign busy_count = cnt_q;

endmodule
